ttc_prescaler_lite: RTL

//  Clock-source selection and prescaler for one timer/counter channel; upstream of the channel counter.

---
 rtl/ttc_pkg.sv | 16 +
 rtl/ttc_ext_clk_sync.sv | 34 +++
 rtl/ttc_prescaler_lite.sv | 85 ++++++++
 3 files changed

// File: rtl/ttc_pkg.sv
// Shared constants for the timer/counter channel blocks.
// Field positions of the clock control register and counter widths.
// Pure declarations; no logic.
package ttc_pkg;

  localparam int CLK_CTRL_W    = 7;
  localparam int PRE_CNT_W     = 16;

  // clock control register field positions
  localparam int CLK_PRE_EN    = 0;
  localparam int CLK_PRE_N_LSB = 1;
  localparam int CLK_PRE_N_MSB = 4;
  localparam int CLK_SRC_SEL   = 5;
  localparam int CLK_EDGE_SEL  = 6;

endpackage

// File: rtl/ttc_ext_clk_sync.sv
// Synchronises an asynchronous external clock into the pclk domain and detects its edges.
// Latency: rise/fall assert SYNC_STAGES cycles after ext_clk is first sampled at its new level.
// No backpressure; rise/fall are single-cycle combinational decodes of registered state.
module ttc_ext_clk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ext_clk,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ext_q;
  logic                   ext_d;

  assign ext_q = sync[SYNC_STAGES-1];

  // shift ext_clk through the synchroniser chain, then one extra flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      ext_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], ext_clk};
      ext_d <= ext_q;
    end
  end

  assign rise = ext_q & ~ext_d;
  assign fall = ~ext_q & ext_d;

endmodule

// File: rtl/ttc_prescaler_lite.sv
// Clock-source select and 2^(N+1) prescaler producing the count_en strobe for one channel.
// Latency: count_en is registered; one cycle after the qualifying tick (ext source adds synchroniser delay).
// No backpressure; a register write drops the tick of that cycle and restarts the prescale count.
module ttc_prescaler_lite
  import ttc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  p_reset,
  input  logic [CLK_CTRL_W-1:0] pwdata,
  input  logic                  clk_ctrl_reg_sel,
  input  logic                  ext_clk,
  output logic                  count_en,
  output logic [CLK_CTRL_W-1:0] clk_ctrl_reg_out
);

  logic [CLK_CTRL_W-1:0] clk_ctrl_reg;
  logic [PRE_CNT_W-1:0]  pre_cnt;
  logic [PRE_CNT_W:0]    term_full;
  logic [PRE_CNT_W-1:0]  term;
  logic [3:0]            pre_n;
  logic                  pre_en;
  logic                  src_sel;
  logic                  edge_sel;
  logic                  ext_rise;
  logic                  ext_fall;
  logic                  src_tick;

  ttc_ext_clk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ext_sync (
    .clk    (pclk),
    .reset  (p_reset),
    .ext_clk(ext_clk),
    .rise   (ext_rise),
    .fall   (ext_fall)
  );

  assign pre_en   = clk_ctrl_reg[CLK_PRE_EN];
  assign pre_n    = clk_ctrl_reg[CLK_PRE_N_MSB:CLK_PRE_N_LSB];
  assign src_sel  = clk_ctrl_reg[CLK_SRC_SEL];
  assign edge_sel = clk_ctrl_reg[CLK_EDGE_SEL];

  // terminal count computed one bit wide so N=15 yields 16'hFFFF after truncation
  assign term_full = ((PRE_CNT_W+1)'(1) << ({1'b0, pre_n} + 5'd1)) - (PRE_CNT_W+1)'(1);
  assign term      = term_full[PRE_CNT_W-1:0];

  // tick source: every pclk, or the selected edge of the synchronised external clock
  always_comb begin
    src_tick = 1'b1;
    if (src_sel) begin
      src_tick = edge_sel ? ext_fall : ext_rise;
    end
  end

  // control register, prescale counter and count_en strobe; a write restarts counting
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      clk_ctrl_reg <= '0;
      pre_cnt      <= '0;
      count_en     <= 1'b0;
    end else if (clk_ctrl_reg_sel) begin
      clk_ctrl_reg <= pwdata;
      pre_cnt      <= '0;
      count_en     <= 1'b0;
    end else if (!pre_en) begin
      pre_cnt      <= '0;
      count_en     <= src_tick;
    end else if (src_tick) begin
      if (pre_cnt == term) begin
        pre_cnt    <= '0;
        count_en   <= 1'b1;
      end else begin
        pre_cnt    <= pre_cnt + PRE_CNT_W'(1);
        count_en   <= 1'b0;
      end
    end else begin
      count_en     <= 1'b0;
    end
  end

  assign clk_ctrl_reg_out = clk_ctrl_reg;

endmodule
